one_hot_reg_bank: RTL and testbench

ONE_HOT_REG_BANK -- requirements
Module: one_hot_reg_bank

---
 rtl/one_hot_reg_bank_pkg.sv | 18 +
 rtl/one_hot_reg_bank_onehot_check.sv | 32 +++
 rtl/one_hot_reg_bank.sv | 66 ++++++
 tb/tb_one_hot_reg_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/one_hot_reg_bank_pkg.sv
// Shared constants and types for the one-hot register bank.
// Optional build macro ONE_HOT_REG_BANK_BYPASS_EN (see one_hot_reg_bank.sv).
package one_hot_reg_bank_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        SEL_NONE    = 2'd0,
        SEL_LEGAL   = 2'd1,
        SEL_ILLEGAL = 2'd2
    } sel_kind_t;

endpackage

// File: rtl/one_hot_reg_bank_onehot_check.sv
// Classifies a write select as none / single-hot / multi-hot and encodes the
// selected index (index is only meaningful when the select is legal).
module onehot_check
    import one_hot_reg_bank_pkg::*;
#(
    parameter logic [63:0] UUID = 64'd0
) (
    input  logic [NUM_REGS-1:0] sel,
    output sel_kind_t           kind,
    output logic [ADDR_W-1:0]   idx
);

    logic [ADDR_W:0] ones;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) begin
                ones = ones + 1'b1;
                idx  = ADDR_W'(i);
            end
        end
        if (ones == '0)
            kind = SEL_NONE;
        else if (ones == (ADDR_W+1)'(1))
            kind = SEL_LEGAL;
        else
            kind = SEL_ILLEGAL;
    end

endmodule

// File: rtl/one_hot_reg_bank.sv
// Eight-entry register bank written through a one-hot select, with two read
// ports and illegal-select tracking. ONE_HOT_REG_BANK_BYPASS_EN adds write-to-read bypass.
module one_hot_reg_bank
    import one_hot_reg_bank_pkg::*;
#(
    parameter logic [63:0] UUID = 64'd0,
    parameter              NAME = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REGS-1:0] wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                clr_err,
    output logic                sel_err,
    output logic [7:0]          err_cnt
);

    data_t                regs [NUM_REGS];
    sel_kind_t            kind;
    logic [ADDR_W-1:0]    wr_idx;

    onehot_check #(
        .UUID (UUID ^ 64'd1)
    ) u_check (
        .sel  (wr_sel),
        .kind (kind),
        .idx  (wr_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (kind == SEL_LEGAL)
                regs[wr_idx] <= wr_data;
            // A clear that coincides with an illegal select restarts the count at one.
            if (clr_err) begin
                sel_err <= (kind == SEL_ILLEGAL);
                err_cnt <= (kind == SEL_ILLEGAL) ? 8'd1 : 8'd0;
            end else if (kind == SEL_ILLEGAL) begin
                sel_err <= 1'b1;
                if (err_cnt != ERR_CNT_MAX)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef ONE_HOT_REG_BANK_BYPASS_EN
        if (kind == SEL_LEGAL && wr_idx == rd_addr_a)
            rd_data_a = wr_data;
        if (kind == SEL_LEGAL && wr_idx == rd_addr_b)
            rd_data_b = wr_data;
`endif
    end

endmodule

// File: tb/tb_one_hot_reg_bank.sv
// Self-checking bench for one_hot_reg_bank: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_one_hot_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_sel = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] rd_addr_a = '0;
    logic [2:0] rd_addr_b = '0;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic       clr_err = 1'b0;
    logic       sel_err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_regs [8];
    logic       m_err;
    int         m_cnt;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] data;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       clr;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    one_hot_reg_bank #(.UUID(64'h0), .NAME("tb")) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .clr_err   (clr_err),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] addr);
`ifdef ONE_HOT_REG_BANK_BYPASS_EN
        if ($countones(wr_sel) == 1 && wr_sel[addr]) return wr_data;
`endif
        return m_regs[addr];
    endfunction

    // Advance one clock; the model follows the rules at the sampled edge.
    task automatic cycle();
        int n;
        @(posedge clk);
        n = $countones(wr_sel);
        if (rst) begin
            if (n == 1)
                for (int i = 0; i < 8; i++) if (wr_sel[i]) m_regs[i] = wr_data;
            if (clr_err) begin
                m_err = (n >= 2);
                m_cnt = (n >= 2) ? 1 : 0;
            end else if (n >= 2) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic idle();
        wr_sel = '0;
        clr_err = 1'b0;
    endtask

    initial begin
        model_reset();
        // Table: write sequence, illegal select, hold, collision, clear.
        for (int i = 0; i < 8; i++) begin
            vecs[i].sel     = 8'(1 << i);
            vecs[i].data    = 8'h10 + 8'(i);
            vecs[i].ra      = 3'(i);
            vecs[i].rb      = 3'(7 - i);
            vecs[i].clr     = 1'b0;
            vecs[i].exp_a   = 8'h10 + 8'(i);
            vecs[i].exp_b   = (7 - i <= i) ? 8'h10 + 8'(7 - i) : 8'h00;
            vecs[i].exp_err = 1'b0;
            vecs[i].exp_cnt = 8'd0;
        end
        vecs[8]  = '{8'h03, 8'hFF, 3'd0, 3'd1, 1'b0, 8'h10, 8'h11, 1'b1, 8'd1};
        vecs[9]  = '{8'h00, 8'hEE, 3'd2, 3'd2, 1'b0, 8'h12, 8'h12, 1'b1, 8'd1};
        vecs[10] = '{8'hC0, 8'h99, 3'd6, 3'd7, 1'b1, 8'h16, 8'h17, 1'b1, 8'd1};
        vecs[11] = '{8'h00, 8'h00, 3'd3, 3'd4, 1'b1, 8'h13, 8'h14, 1'b0, 8'd0};

        // Reset state
        #1;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd7;
        #1;
        check("reset_rd_a", 32'(rd_data_a), 32'h0);
        check("reset_rd_b", 32'(rd_data_b), 32'h0);
        check("reset_err", 32'(sel_err), 32'h0);
        check("reset_cnt", 32'(err_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[k]) begin
            wr_sel    = vecs[k].sel;
            wr_data   = vecs[k].data;
            rd_addr_a = vecs[k].ra;
            rd_addr_b = vecs[k].rb;
            clr_err   = vecs[k].clr;
            cycle();
            idle();
            #1;
            check($sformatf("vec%0d_rd_a", k), 32'(rd_data_a), 32'(vecs[k].exp_a));
            check($sformatf("vec%0d_rd_b", k), 32'(rd_data_b), 32'(vecs[k].exp_b));
            check($sformatf("vec%0d_err", k), 32'(sel_err), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_cnt", k), 32'(err_cnt), 32'(vecs[k].exp_cnt));
        end

        // Saturation then clear
        wr_sel = 8'hF0;
        repeat (300) cycle();
        idle();
        #1;
        check("sat_cnt", 32'(err_cnt), 32'd255);
        check("sat_err", 32'(sel_err), 32'd1);
        clr_err = 1'b1;
        cycle();
        idle();
        #1;
        check("sat_clr_cnt", 32'(err_cnt), 32'd0);
        check("sat_clr_err", 32'(sel_err), 32'd0);

        // Clear colliding with illegal select at err_cnt=9
        wr_sel = 8'h81;
        repeat (9) cycle();
        idle();
        #1;
        check("coll_pre_cnt", 32'(err_cnt), 32'd9);
        wr_sel  = 8'hC0;
        clr_err = 1'b1;
        cycle();
        idle();
        #1;
        check("coll_err", 32'(sel_err), 32'd1);
        check("coll_cnt", 32'(err_cnt), 32'd1);

        // Mid-operation reset
        wr_sel  = 8'h08;
        wr_data = 8'h77;
        cycle();
        idle();
        rd_addr_a = 3'd3;
        #2;
        check("r3_loaded", 32'(rd_data_a), 32'h77);
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_err", 32'(sel_err), 32'd0);
        check("arst_cnt", 32'(err_cnt), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = 3'(a);
            rd_addr_b = 3'(7 - a);
            #1;
            check($sformatf("arst_rd_a%0d", a), 32'(rd_data_a), 32'h0);
            check($sformatf("arst_rd_b%0d", a), 32'(rd_data_b), 32'h0);
        end
        wr_sel  = 8'h08;
        wr_data = 8'h55;
        rd_addr_a = 3'd3;
        cycle();
        idle();
        #1;
        check("rst_write_discard", 32'(rd_data_a), 32'h0);
        // Release between edges with a write pending: it lands on the next edge.
        wr_sel  = 8'h04;
        wr_data = 8'h3C;
        rst     = 1'b1;
        rd_addr_b = 3'd2;
        cycle();
        idle();
        #1;
        check("rst_release_write", 32'(rd_data_b), 32'h3C);

        // Same-cycle write/read on r5 (still zero)
        wr_sel    = 8'h20;
        wr_data   = 8'hA5;
        rd_addr_a = 3'd5;
        #1;
`ifdef ONE_HOT_REG_BANK_BYPASS_EN
        check("same_cycle_rd", 32'(rd_data_a), 32'hA5);
`else
        check("same_cycle_rd", 32'(rd_data_a), 32'h00);
`endif
        cycle();
        idle();
        #1;
        check("next_cycle_rd", 32'(rd_data_a), 32'hA5);
        // Multi-hot select touching r6 must not be bypassed in any build.
        wr_sel    = 8'h41;
        wr_data   = 8'hDD;
        rd_addr_a = 3'd6;
        #1;
        check("no_bypass_illegal", 32'(rd_data_a), 32'h00);
        cycle();
        idle();

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 3))
                0: wr_sel = '0;
                1, 2: wr_sel = 8'(1 << $urandom_range(0, 7));
                default: wr_sel = 8'($urandom);
            endcase
            wr_data   = 8'($urandom);
            rd_addr_a = 3'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom);
            clr_err   = ($urandom_range(0, 15) == 0);
            #1;
            check("rnd_rd_a", 32'(rd_data_a), 32'(model_read(rd_addr_a)));
            check("rnd_rd_b", 32'(rd_data_b), 32'(model_read(rd_addr_b)));
            cycle();
            check("rnd_err", 32'(sel_err), 32'(m_err));
            check("rnd_cnt", 32'(err_cnt), 32'(m_cnt));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
